hazard_ctrl_unit: RTL
=====================

// Module: hazard_ctrl_unit
// PURPOSE
//  Pipeline hazard controller driving the stall/flush inputs of the IF/ID, ID/EX and EX/MEM registers.
//  Detects load-use hazards between ID and EX, squashes wrong-path fetches on a taken branch resolved in EX,
//  and freezes the front end while a multi-cycle EX operation (mul/div) runs. It is the producer side of the
//  pipeline-register stall/flush interface.
// PARAMETERS
//  REG_COUNT    32   architectural registers; address width = $clog2(REG_COUNT)
//  FLUSH_CYCLES 1    cycles if_id_flush stays high after a taken branch (fetch latency), >=1
//  MC_TIMEOUT   64   max MC_WAIT cycles before mc_timeout is raised, >=2
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   synchronous reset, active-low
//  id_rs1_addr      in   AW  rs1 of instruction in ID
//  id_rs2_addr      in   AW  rs2 of instruction in ID
//  id_uses_rs1      in   1   ID instruction reads rs1
//  id_uses_rs2      in   1   ID instruction reads rs2
//  ex_rd_addr       in   AW  rd of instruction in EX (ID/EX output)
//  ex_mem_read      in   1   EX instruction is a load
//  ex_branch_taken  in   1   branch/jump in EX resolved taken
//  ex_mc_start      in   1   EX issues a multi-cycle op this cycle
//  ex_mc_done       in   1   multi-cycle op result valid this cycle
//  pc_write_en      out  1   PC update enable
//  if_id_write_en   out  1   IF/ID load enable (0 = hold)
//  if_id_flush      out  1   IF/ID insert bubble
//  id_ex_flush      out  1   ID/EX insert bubble
//  id_ex_hold       out  1   ID/EX clock-enable low (keep EX operands)
//  ex_mem_bubble    out  1   EX/MEM insert bubble
//  mc_timeout       out  1   sticky error: multi-cycle op exceeded MC_TIMEOUT
//  stall_cnt        out  32  stall-cycle counter (perf option)
//  flush_cnt        out  32  flush-cycle counter (perf option)
// BEHAVIOUR
//  State reg: RUN, FLUSH, MC_WAIT. Outputs combinational from state + inputs; state/counters registered.
//  Reset (rst=0 at edge): state<=RUN, flush/timeout counters<=0, mc_timeout<=0. While rst=0 outputs forced:
//   pc_write_en=0, if_id_write_en=0, if_id_flush=1, id_ex_flush=1, id_ex_hold=0, ex_mem_bubble=1.
//  Default (RUN, no event): pc_write_en=1, if_id_write_en=1, all flush/bubble/hold=0.
//  Load-use (RUN): ex_mem_read && ex_rd_addr!=0 && ((id_uses_rs1&&rs1==rd)||(id_uses_rs2&&rs2==rd)):
//   same cycle pc_write_en=0, if_id_write_en=0, id_ex_flush=1; exactly one bubble, state stays RUN.
//  Taken branch (RUN): same cycle if_id_flush=1, id_ex_flush=1, pc_write_en=1 (loads target).
//   FLUSH_CYCLES>1 -> FLUSH for FLUSH_CYCLES-1 cycles with if_id_flush=1 only; counter restarts on new taken.
//  Multi-cycle (RUN, ex_mc_start && !ex_mc_done) -> MC_WAIT. In MC_WAIT: pc_write_en=0, if_id_write_en=0,
//   id_ex_hold=1, ex_mem_bubble=1. ex_mc_done -> RUN, outputs default that cycle. start&&done same cycle: stay RUN.
//  Timeout: MC_WAIT count reaches MC_TIMEOUT -> mc_timeout=1 (sticky until reset), state stays MC_WAIT.
//  Priority same cycle: taken branch > multi-cycle start > load-use. Branch wins: mc_start ignored, no stall.
//  rs/rd address 0 never creates a hazard. Reset mid-MC_WAIT/FLUSH: abandoned, RUN next cycle.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: stall_cnt +1 each cycle pc_write_en=0 (not in reset), flush_cnt +1 each cycle
//   if_id_flush=1 (not in reset); both saturate at 2^32-1, cleared by reset.
//  Undefined: counters not built, stall_cnt/flush_cnt tied to 0; ports remain.
// STRUCTURE
//  hazard_pkg: hz_state_t enum {RUN,FLUSH,MC_WAIT}, REG_ADDR_W function/const, counter width const.
//  Sub-module hazard_perf_counter (saturating 32-bit counter w/ inc + sync clear), instanced twice under macro.
// TESTING
//  Load x5 in EX, ID add uses rs2=x5 -> 1 cycle pc_write_en=0, id_ex_flush=1; next cycle defaults.
//  Load rd=x0, ID uses rs1=x0 -> no stall; load x5, ID uses_rs1=0 with rs1=x5 -> no stall.
//  Taken branch, FLUSH_CYCLES=3 -> if_id_flush high 3 cycles, id_ex_flush high 1st cycle only.
//  mc_start, done 10 cycles later -> hold/bubble high 10 cycles; done with MC_TIMEOUT=4 late -> mc_timeout=1 sticky.
//  Branch+load-use same cycle -> flush only, pc_write_en=1; branch+mc_start -> stays RUN.
//  rst=0 mid-MC_WAIT -> forced reset outputs, RUN after release; perf counters match counted cycles, 0 w/o macro.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MC_WAIT = 2'd2
  } hz_state_t;

  localparam int PERF_CNT_W = 32;

  function automatic int reg_addr_w(input int reg_count);
    return (reg_count > 1) ? $clog2(reg_count) : 1;
  endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with synchronous clear, used for stall/flush statistics.
module hazard_perf_counter
  import hazard_pkg::*;
(
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  inc,
  output logic [PERF_CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + PERF_CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / taken-branch / multi-cycle-op hazard controller for the IF/ID, ID/EX, EX/MEM registers.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
//
// state   | meaning
// RUN     | normal flow; load-use stalls and branch squash handled in-cycle
// FLUSH   | extra wrong-path fetch squash cycles after a taken branch
// MC_WAIT | front end and EX frozen until the multi-cycle op completes
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter  int REG_COUNT    = 32,
  parameter  int FLUSH_CYCLES = 1,
  parameter  int MC_TIMEOUT   = 64,
  localparam int AW           = reg_addr_w(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AW-1:0]         id_rs1_addr,
  input  logic [AW-1:0]         id_rs2_addr,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [AW-1:0]         ex_rd_addr,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mc_start,
  input  logic                  ex_mc_done,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  id_ex_hold,
  output logic                  ex_mem_bubble,
  output logic                  mc_timeout,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam int TW = $clog2(MC_TIMEOUT + 1);

  hz_state_t       state_q, state_nxt;
  logic [FW-1:0]   flush_q, flush_nxt;
  logic [TW-1:0]   tmo_q, tmo_nxt;
  logic            tmo_set;
  logic            load_use;

  // x0 can never match: rd must be nonzero, so any matching rs is nonzero too
  assign load_use = ex_mem_read && (ex_rd_addr != '0) &&
                    ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                     (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));

  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    id_ex_hold     = 1'b0;
    ex_mem_bubble  = 1'b0;
    state_nxt      = state_q;
    flush_nxt      = flush_q;
    tmo_nxt        = tmo_q;
    tmo_set        = 1'b0;

    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            flush_nxt = FW'(FLUSH_CYCLES - 1);
          end
        end else if (ex_mc_start && !ex_mc_done) begin
          // freeze in the issue cycle so the op is not overwritten in EX
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_ex_hold     = 1'b1;
          ex_mem_bubble  = 1'b1;
          state_nxt      = MC_WAIT;
          tmo_nxt        = TW'(MC_TIMEOUT);
        end else if (load_use) begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_ex_flush    = 1'b1;
        end
      end
      FLUSH: begin
        if_id_flush = 1'b1;
        if (ex_branch_taken) begin
          id_ex_flush = 1'b1;
          flush_nxt   = FW'(FLUSH_CYCLES - 1);
        end else if (flush_q == FW'(1)) begin
          state_nxt = RUN;
        end else begin
          flush_nxt = flush_q - FW'(1);
        end
      end
      MC_WAIT: begin
        if (ex_mc_done) begin
          state_nxt = RUN;
        end else begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          id_ex_hold     = 1'b1;
          ex_mem_bubble  = 1'b1;
          if (tmo_q == TW'(1)) begin
            tmo_set = 1'b1;
          end else begin
            tmo_nxt = tmo_q - TW'(1);
          end
        end
      end
      default: state_nxt = RUN;
    endcase

    if (!rst) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      id_ex_hold     = 1'b0;
      ex_mem_bubble  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= RUN;
      flush_q    <= '0;
      tmo_q      <= '0;
      mc_timeout <= 1'b0;
    end else begin
      state_q <= state_nxt;
      flush_q <= flush_nxt;
      tmo_q   <= tmo_nxt;
      if (tmo_set) mc_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counter u_stall_cnt (
    .clk (clk),
    .clr (!rst),
    .inc (!pc_write_en),
    .cnt (stall_cnt)
  );

  hazard_perf_counter u_flush_cnt (
    .clk (clk),
    .clr (!rst),
    .inc (if_id_flush),
    .cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
